md_unit_ctrl: RTL

//  Multi-cycle multiply/divide sequencer with HI/LO register file for the pipelined MIPS core.

---
 rtl/md_unit_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer that owns the HI/LO registers.
// The result is computed when the op is accepted. A countdown then holds busy
// high for the op's fixed latency, and the result is written to HI/LO when the
// countdown ends.
// Optional feature: define MD_CANCEL_EN to add the cancel input (exception/flush abort).
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        res_hi_q;
  logic [31:0]        res_lo_q;
  logic               skip_q;

  logic [31:0]        res_hi_d;
  logic [31:0]        res_lo_d;
  logic               skip_d;
  logic               cancel_w;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        b_u;
  logic               div_ovf;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Result of the op presented at the inputs; latched only when the op is accepted.
  // Division by zero and the signed overflow case substitute a divisor of 1. For
  // 0x80000000 / -1 that gives lo=0x80000000, hi=0. The value computed for a zero
  // divisor is discarded, because the commit is suppressed for it.
  always_comb begin
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'd0, a} * {32'd0, b};
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    a_s      = $signed(a);
    b_s      = ((b == 32'd0) || div_ovf) ? 32'sd1 : $signed(b);
    quot_s   = a_s / b_s;
    rem_s    = a_s % b_s;
    b_u      = (b == 32'd0) ? 32'd1 : b;
    skip_d   = op[1] && (b == 32'd0);
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (op[1:0])
      2'd0:    begin res_hi_d = prod_s[63:32]; res_lo_d = prod_s[31:0]; end
      2'd1:    begin res_hi_d = prod_u[63:32]; res_lo_d = prod_u[31:0]; end
      2'd2:    begin res_hi_d = rem_s;         res_lo_d = quot_s;       end
      default: begin res_hi_d = a % b_u;       res_lo_d = a / b_u;      end
    endcase
  end

  // Two-state sequencer: accept ops in IDLE, count down in RUN, commit when the count reaches 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      skip_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel_w) begin
            if (!op[2]) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              skip_q   <= skip_d;
              cnt_q    <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else if (op == 3'd4) begin
              hi_q <= a;
            end else if (op == 3'd5) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          if (cancel_w) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            if (!skip_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Stall later HI/LO users while an op is in flight or being issued this cycle.
  assign stall = md_use & (busy_q | (start & ~op[2]));
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
